// File: rtl/timer_pkg.sv
// Shared register map and CTRL layout for the timer_ports I/O block.
package timer_pkg;

  localparam logic TIMER_RELOAD = 1'b0;
  localparam logic TIMER_CTRL   = 1'b1;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;
  localparam int unsigned CTRL_PENDING  = 15;

  typedef struct packed {
    logic        pending;
    logic [11:0] rsvd;
    logic        irq_en;
    logic        periodic;
    logic        en;
  } timer_ctrl_t;

endpackage

// File: rtl/timer_prescaler.sv
// Divides clk by prescale; tick is a one-cycle strobe on the wrap cycle.
module timer_prescaler #(
  parameter int unsigned prescale = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int unsigned W = $clog2(prescale);
  localparam logic [W-1:0] LAST = W'(prescale - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A restart in the wrap cycle swallows that tick
  assign tick = enable & ~restart & (cnt == LAST);

endmodule

// File: rtl/timer_ports.sv
// 16-bit interval timer on the I/O data bus with a level irq output.
// Define TIMER_READBACK_EN to read the live COUNT at address 0 instead of RELOAD.
module timer_ports
  import timer_pkg::*;
#(
  parameter int unsigned prescale = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        data_m_access,
  input  logic        data_m_addr,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  input  logic [15:0] data_m_data_in,
  output logic [15:0] data_m_data_out,
  output logic        data_m_ack,
  output logic        irq
);

  logic        req_q;
  logic        accept;
  logic        wr_reload;
  logic        wr_ctrl;
  logic        ctrl_lo;
  logic        en_change;
  logic        tick;
  logic [15:0] reload;
  logic [15:0] count;
  logic [15:0] rd_data;
  logic        en;
  logic        periodic;
  logic        irq_en;
  logic        pending;
  timer_ctrl_t ctrl_rd;

  // A request held across cycles is accepted only on its first cycle
  assign accept    = cs & data_m_access & ~req_q;
  assign wr_reload = accept & data_m_wr_en & (data_m_addr == TIMER_RELOAD);
  assign wr_ctrl   = accept & data_m_wr_en & (data_m_addr == TIMER_CTRL);
  assign ctrl_lo   = wr_ctrl & data_m_bytesel[0];
  assign en_change = ctrl_lo & (data_m_data_in[CTRL_EN] != en);

  timer_prescaler #(.prescale(prescale)) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (en),
    .restart(en_change),
    .tick   (tick)
  );

  always_comb begin
    ctrl_rd = '{pending: pending, rsvd: '0, irq_en: irq_en, periodic: periodic, en: en};
    rd_data = '0;
    if (data_m_addr == TIMER_CTRL) begin
      rd_data = ctrl_rd;
    end else begin
`ifdef TIMER_READBACK_EN
      rd_data = count;
`else
      rd_data = reload;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q           <= 1'b0;
      data_m_ack      <= 1'b0;
      data_m_data_out <= '0;
      irq             <= 1'b0;
    end else begin
      req_q           <= cs & data_m_access;
      data_m_ack      <= accept;
      data_m_data_out <= (accept & ~data_m_wr_en) ? rd_data : '0;
      irq             <= pending & irq_en;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload   <= '0;
      count    <= '0;
      en       <= 1'b0;
      periodic <= 1'b0;
      irq_en   <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (wr_reload) begin
        if (data_m_bytesel[0]) reload[7:0]  <= data_m_data_in[7:0];
        if (data_m_bytesel[1]) reload[15:8] <= data_m_data_in[15:8];
      end
      if (ctrl_lo) begin
        en       <= data_m_data_in[CTRL_EN];
        periodic <= data_m_data_in[CTRL_PERIODIC];
        irq_en   <= data_m_data_in[CTRL_IRQ_EN];
        if (data_m_data_in[CTRL_EN] && !en) count <= reload;
      end
      if (wr_ctrl && data_m_bytesel[1] && data_m_data_in[CTRL_PENDING]) pending <= 1'b0;
      // Expiry is last so it overrides a same-cycle PENDING clear and one-shot EN
      if (tick) begin
        if (count > 16'd1) begin
          count <= count - 1'b1;
        end else begin
          pending <= 1'b1;
          if (periodic) begin
            count <= reload;
          end else begin
            en    <= 1'b0;
            count <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_ports.sv
// Randomized scoreboard bench for timer_ports; expiry times come from an event model.
module tb_timer_ports;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        acc = 1'b0;
  logic        addr = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  bs = 2'b00;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        ack;
  logic        irq;

  always #5 clk = ~clk;

  timer_ports #(.prescale(P)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cs             (cs),
    .data_m_access  (acc),
    .data_m_addr    (addr),
    .data_m_wr_en   (wr),
    .data_m_bytesel (bs),
    .data_m_data_in (din),
    .data_m_data_out(dout),
    .data_m_ack     (ack),
    .irq            (irq)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  logic [15:0] sb[$];

  // Reference model: registers plus absolute edge numbers of the next expiry
  logic [15:0] m_reload;
  bit m_en, m_per, m_irqen, m_pending, m_irq, m_ack, m_req_prev;
  int m_base, m_base_cnt, m_next_exp, m_frozen;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, got, exp, edge_n);
    end
  endfunction

  function automatic void model_reset();
    m_reload = '0; m_en = 0; m_per = 0; m_irqen = 0; m_pending = 0;
    m_irq = 0; m_ack = 0; m_req_prev = 0;
    m_base = 0; m_base_cnt = 0; m_next_exp = 0; m_frozen = 0;
    sb.delete();
  endfunction

  // COUNT as it stood just before edge e
  function automatic int count_before(int e);
    if (!m_en) return m_frozen;
    return m_base_cnt - (e - 1 - m_base) / P;
  endfunction

  function automatic logic [15:0] read_value(logic a);
    if (a) return {m_pending, 12'h000, m_irqen, m_per, m_en};
`ifdef TIMER_READBACK_EN
    return 16'(count_before(edge_n));
`else
    return m_reload;
`endif
  endfunction

  function automatic int period(logic [15:0] r);
    return P * ((r == 0) ? 1 : int'(r));
  endfunction

  function automatic void model_edge();
    bit req, accept, en_change, expire, per_old, irq_next;
    logic [15:0] reload_old;
    req = cs && acc;
    accept = req && !m_req_prev;
    m_req_prev = req;
    irq_next = m_pending && m_irqen;
    per_old = m_per;
    reload_old = m_reload;
    en_change = accept && wr && addr && bs[0] && (din[0] != m_en);
    expire = m_en && !en_change && (edge_n == m_next_exp);
    if (accept) sb.push_back(wr ? 16'h0000 : read_value(addr));
    if (accept && wr && !addr) begin
      if (bs[0]) m_reload[7:0] = din[7:0];
      if (bs[1]) m_reload[15:8] = din[15:8];
    end
    if (accept && wr && addr) begin
      if (bs[0]) begin
        if (en_change && din[0]) begin
          m_base = edge_n; m_base_cnt = reload_old;
          m_next_exp = edge_n + period(reload_old);
        end else if (en_change) begin
          m_frozen = count_before(edge_n);
        end
        m_en = din[0]; m_per = din[1]; m_irqen = din[2];
      end
      if (bs[1] && din[15]) m_pending = 0;
    end
    if (expire) begin
      m_pending = 1;
      if (per_old) begin
        m_base = edge_n; m_base_cnt = reload_old;
        m_next_exp = edge_n + period(reload_old);
      end else begin
        m_en = 0; m_frozen = 0;
      end
    end
    m_ack = accept;
    m_irq = irq_next;
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check("ack", ack, m_ack);
    check("irq", irq, m_irq);
    if (!m_ack) check("idle_data", dout, 0);
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic bus(logic a, logic w, logic [1:0] b, logic [15:0] d);
    @(negedge clk);
    cs = 1; acc = 1; addr = a; wr = w; bs = b; din = d;
    step();
    @(negedge clk);
    cs = 0; acc = 0; wr = 0;
    step();
  endtask

  task automatic held_read(logic a);
    @(negedge clk);
    cs = 1; acc = 1; addr = a; wr = 0; bs = 2'b11;
    repeat (3) step();
    @(negedge clk);
    cs = 0; acc = 0;
    step();
  endtask

  // Reset lands in the middle of a pending ack
  task automatic reset_mid();
    @(negedge clk);
    cs = 1; acc = 1; addr = 1; wr = 0; bs = 2'b11;
    step();
    #1 reset_n = 0;
    #1;
    check("rst_ack", ack, 0);
    check("rst_irq", irq, 0);
    check("rst_data", dout, 0);
    cs = 0; acc = 0;
    model_reset();
    repeat (2) begin @(posedge clk); edge_n++; end
    @(negedge clk);
    reset_n = 1;
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (reset_n && ack) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL ack_unexpected: got ack=1 expected no access outstanding (edge %0d)", edge_n);
      end else begin
        e = sb.pop_front();
        check("bus_data", dout, e);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int en_edge, guard, op;
    logic [15:0] d;
    logic [1:0] b;
    model_reset();
    cs = 1; acc = 1; addr = 1; wr = 0; bs = 2'b11;
    repeat (2) begin @(posedge clk); edge_n++; end
    #1;
    check("init_ack", ack, 0);
    check("init_irq", irq, 0);
    check("init_data", dout, 0);
    @(negedge clk);
    cs = 0; acc = 0; reset_n = 1;
    idle(2);
    bus(1, 0, 2'b11, 16'h0);
    bus(0, 0, 2'b11, 16'h0);

    // byte enables and the no-op bytesel
    bus(0, 1, 2'b01, 16'hABCD);
    bus(0, 1, 2'b10, 16'h1200);
    bus(0, 0, 2'b11, 16'h0);
    check("reload_bytes", m_reload, 16'h12CD);
    bus(1, 1, 2'b00, 16'hFFFF);
    bus(1, 0, 2'b11, 16'h0);
    held_read(1);

    // one-shot: irq rises 13 edges after the enabling edge
    bus(0, 1, 2'b11, 16'd3);
    bus(1, 1, 2'b11, 16'h0005);
    en_edge = edge_n - 1;
    guard = 0;
    while (irq !== 1'b1 && guard < 40) begin step(); guard++; end
    check("oneshot_lat", edge_n - en_edge, 13);
    idle(3);
    bus(1, 0, 2'b11, 16'h0);
    bus(1, 1, 2'b10, 16'h8000);
    bus(1, 0, 2'b11, 16'h0);

    // periodic with a clear between expiries
    bus(0, 1, 2'b11, 16'd2);
    bus(1, 1, 2'b11, 16'h0007);
    idle(20);
    bus(1, 1, 2'b11, 16'h8007);
    bus(1, 0, 2'b11, 16'h0);
    idle(12);
    bus(1, 0, 2'b11, 16'h0);

    // clear lands on the expiry edge
    guard = 0;
    while (edge_n + 1 != m_next_exp && guard < 40) begin step(); guard++; end
    bus(1, 1, 2'b10, 16'h8000);
    check("collision_model", m_pending, 1);
    bus(1, 0, 2'b11, 16'h0);
    idle(3);
    reset_mid();
    idle(2);
    bus(1, 0, 2'b11, 16'h0);

    // address 0 while counting down from 100
    bus(0, 1, 2'b11, 16'd100);
    bus(1, 1, 2'b11, 16'h0001);
    repeat (5) begin idle(37); bus(0, 0, 2'b11, 16'h0); end
    bus(1, 1, 2'b01, 16'h0000);
    bus(0, 0, 2'b11, 16'h0);

    for (int i = 0; i < 200; i++) begin
      op = $urandom_range(0, 9);
      d = 16'($urandom);
      b = 2'($urandom_range(0, 3));
      case (op)
        0, 1, 2, 3: bus(1'($urandom_range(0, 1)), 0, b, d);
        4:          bus(0, 1, b, 16'($urandom_range(0, 5)));
        5, 6:       bus(1, 1, b, {d[15], 12'h000, d[2:0]});
        7: begin
          @(negedge clk);
          cs = 0; acc = 1; addr = d[0]; wr = 1; bs = 2'b11; din = d;
          step();
          @(negedge clk);
          acc = 0; wr = 0;
          step();
        end
        8:       held_read(d[0]);
        default: idle($urandom_range(4, 12));
      endcase
      idle($urandom_range(0, 5));
    end

    idle(3);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ports.md
# timer_ports

Memory-mapped 16-bit interval timer on the CPU I/O data bus. Selected by the top-level I/O address decoder through `cs`, it answers with the same single-cycle `data_m_ack` handshake as the other I/O ports. It drives one interrupt request line into an `IRQController` input. A prescaler derives a tick from `clk`; a down-counter on that tick raises a pending flag in one-shot or periodic mode.

## Interface
- `prescale`, default 50, clk cycles per timer tick (≥2); 50 gives a 1 µs tick at 50 MHz.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  decoder select for this port pair.
- `data_m_access`  in  1  bus access strobe.
- `data_m_addr`  in  1  register select: 0 = RELOAD, 1 = CTRL.
- `data_m_wr_en`  in  1  write when high, read when low.
- `data_m_bytesel`  in  2  byte enables; [0] = bits 7:0, [1] = bits 15:8.
- `data_m_data_in`  in  16  write data.
- `data_m_data_out`  out  16  read data; zero whenever `data_m_ack` is low (OR-bus).
- `data_m_ack`  out  1  one-cycle access completion.
- `irq`  out  1  interrupt request, level.

## Operation
- Registers:
  - RELOAD[15:0]: reset 0.
  - CTRL:
    - bit0 EN, reset 0.
    - bit1 PERIODIC, reset 0.
    - bit2 IRQ_EN, reset 0.
    - bit15 PENDING: read-only status; write 1 clears, write 0 has no effect.
    - Other bits read 0.
- Count register COUNT[15:0]: internal, reset 0.
- Writes honour `data_m_bytesel` per byte. A write with bytesel 00 is acked and changes nothing.
- Writing CTRL with EN going 0→1 does all of the following:
  - loads COUNT with RELOAD;
  - restarts the prescaler;
  - leaves PENDING unchanged.
- Writing RELOAD while EN=1 does not touch COUNT; the new value takes effect on the next reload.
- On each tick while EN=1:
  - COUNT > 1: decrement.
  - COUNT == 1 or COUNT == 0: expire.
    - Set PENDING.
    - If PERIODIC: COUNT ← RELOAD.
    - Else: EN ← 0 and COUNT ← 0.
- RELOAD = 0 expires on the first tick. It is periodic every tick if PERIODIC.
- If an expire and a PENDING-clear write fall in the same cycle, set wins and PENDING = 1.
- If a CTRL write to EN and a tick fall in the same cycle, the write wins and that tick is discarded.
- `irq` = PENDING & IRQ_EN, registered. Reset value 0.
- Prescaler: counts 0..`prescale`-1 while EN=1, tick on wrap. It is held at 0 while EN=0.

## Timing
- Access accepted when `cs & data_m_access`.
- `data_m_ack` is high exactly one cycle later, for one cycle.
- Read data is valid in the ack cycle only.
- Write state updates on the same edge that raises `data_m_ack`.
- A request held high across consecutive cycles is treated as one access. After ack, a new access needs `data_m_access` low for at least one cycle.
- Tick-to-PENDING: PENDING is visible on the edge after the expiring tick. `irq` follows one cycle later.
- Period in periodic mode is (RELOAD)·`prescale` clk cycles for RELOAD ≥ 1.
- Reset asserted mid-count immediately clears:
  - all registers and COUNT;
  - the prescaler;
  - `irq`, `data_m_ack` and `data_m_data_out`.
  No pending ack survives.
- Reset values:
  - `data_m_ack` 0
  - `data_m_data_out` 0
  - `irq` 0

## Configuration
- `TIMER_READBACK_EN`:
  - Defined: a read of address 0 returns the live COUNT.
  - Undefined: a read of address 0 returns RELOAD and COUNT is not observable.
- Write behaviour is identical in both builds.

## Structure
- Package `timer_pkg` holds:
  - register address constants `TIMER_RELOAD = 1'b0` and `TIMER_CTRL = 1'b1`;
  - CTRL bit indices `CTRL_EN = 0`, `CTRL_PERIODIC = 1`, `CTRL_IRQ_EN = 2`, `CTRL_PENDING = 15`;
  - a packed struct for CTRL.
- One sub-module, `timer_prescaler` (parameter `prescale`).
  - Inputs: `clk`, `reset_n`, `enable`, `restart`.
  - Output: `tick`.

## Test plan
- Reset check: reset with activity present → `irq` = 0, `data_m_ack` = 0, `data_m_data_out` = 0; a read of CTRL returns 0x0000.
- One-shot: `prescale` = 4, write RELOAD = 3, write CTRL = 0x0005.
  - PENDING sets 12 clk after the enable edge (±1 edge, per Timing).
  - `irq` rises one cycle later.
  - CTRL then reads 0x8004 (EN cleared).
- Periodic: RELOAD = 2, CTRL = 0x0007 → PENDING sets every 8 clk. Write 0x8000 to CTRL between expiries → PENDING and `irq` drop, then reassert at the next expiry.
- Byte writes: write 0xABCD to RELOAD with bytesel 01, then 0x1200 with bytesel 10 → RELOAD reads 0x12CD.
- Collision: drive a PENDING-clear write on the exact expiry cycle → PENDING stays 1. Toggle reset_n low mid-count → all outputs 0 within the same cycle.
- Readback build: with `TIMER_READBACK_EN` defined, RELOAD = 100 and enabled, address 0 reads decreasing values ≤ 100. Without the macro it reads 100 constantly.
